// File: rtl/cpu_sim_pkg.sv
// Shared types for the CPU step controller.
//   ctl_state_t : controller phases, from image load through CPU pacing to halt
//   run_mode_t  : decoded run mode requested on the mode input
//   decode_mode : maps the 2-bit mode input onto run_mode_t (11 behaves as 01)
package cpu_sim_pkg;

    typedef enum logic [2:0] {
        LOAD,
        RESET,
        IDLE,
        STEP,
        RUN_FREE,
        HALT
    } ctl_state_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        SINGLE = 2'd1,
        NSTEP  = 2'd2
    } run_mode_t;

    function automatic run_mode_t decode_mode(input logic [1:0] mode);
        run_mode_t m;
        unique case (mode)
            2'b00:   m = FREE;
            2'b10:   m = NSTEP;
            default: m = SINGLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cpu_step_controller_byte_packer.sv
// byte_packer: assembles accepted image bytes into ROM words.
//   clk, rstn   : clock, asynchronous active-low reset (drops any partial word)
//   in_accept   : a byte is taken this cycle
//   in_data     : the byte
//   in_last     : this byte ends the image; the remaining byte lanes are zero
//   word_valid  : one-cycle pulse the cycle after a word's final byte
//   word        : the completed word (held until the next word completes)
//   word_last   : the completed word carried in_last
// With BYTE_SWAP=1 the first byte lands in the MSB lane, otherwise in the LSB.
module byte_packer #(
    parameter int WORD_W    = 32,
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_accept,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_last
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [WORD_W-1:0] merged;
    int                pos;

    // The staging buffer is cleared whenever a word is emitted, so a word cut
    // short by in_last is already zero in its unused lanes.
    always_comb begin
        idx_d   = idx_q;
        buf_d   = buf_q;
        word_d  = word_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        merged  = buf_q;
        pos     = 0;
        if (in_accept) begin
            pos = BYTE_SWAP ? (NB - 1 - int'(idx_q)) : int'(idx_q);
            merged[pos*8 +: 8] = in_data;
            if (in_last || (int'(idx_q) == NB - 1)) begin
                word_d  = merged;
                valid_d = 1'b1;
                last_d  = in_last;
                buf_d   = '0;
                idx_d   = '0;
            end else begin
                buf_d = merged;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q   <= '0;
            buf_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;
    assign word_last  = last_q;

endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: boots and paces the CPU core.
//   clk, rstn                  : clock, asynchronous active-low reset
//   in_valid/in_data/in_last   : ROM image byte stream, in_ready handshake
//   rom_we/rom_waddr/rom_wdata : ROM write port (one-cycle strobe per word)
//   mode, step_req, step_count : run control, only acted on in IDLE
//   step_ack                   : one-cycle pulse when the requested steps end
//   ip                         : CPU instruction pointer, checked against ROM depth
//   cpu_rstn, cpu_ce           : CPU reset (active low) and clock enable
//   halted, fault              : sticky halt indication (IP left the ROM)
module cpu_step_controller
    import cpu_sim_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int IP_W         = 16,
    parameter bit BYTE_SWAP    = 1'b1,
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [WORD_W-1:0] rom_wdata,
    input  logic [1:0]        mode,
    input  logic              step_req,
    input  logic [CNT_W-1:0]  step_count,
    output logic              step_ack,
    input  logic [IP_W-1:0]   ip,
    output logic              cpu_rstn,
    output logic              cpu_ce,
    output logic              halted,
    output logic              fault
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ctl_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [CNT_W-1:0]  sc_q, sc_d;

    logic              word_valid;
    logic              word_last;
    logic [WORD_W-1:0] word;
    logic              final_word;
    logic              ip_oob;

    byte_packer #(
        .WORD_W    (WORD_W),
        .BYTE_SWAP (BYTE_SWAP)
    ) u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .in_accept  (in_valid & in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .word_valid (word_valid),
        .word       (word),
        .word_last  (word_last)
    );

    // The top address is the last one the ROM holds; loading stops there
    // rather than wrapping back over address 0.
    assign final_word = word_valid && (word_last || (addr_q == LAST_ADDR));

    // Any IP bit at or above ADDR_W means the core has left the ROM.
    assign ip_oob = cpu_rstn && ((ip >> ADDR_W) != '0);

    // Next-state logic. sc_q holds the clock-enable cycles still owed to the
    // current step request; reaching zero in STEP is the acknowledge cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rc_d    = rc_q;
        sc_d    = sc_q;
        unique case (state_q)
            LOAD: begin
                if (word_valid) begin
                    if (final_word) begin
                        state_d = RESET;
                        rc_d    = RC_W'(RESET_CYCLES - 1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            RESET: begin
                if (rc_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rc_d = rc_q - RC_W'(1);
                end
            end
            IDLE: begin
                if (ip_oob) begin
                    state_d = HALT;
                end else if (step_req) begin
                    unique case (decode_mode(mode))
                        FREE: begin
                            state_d = RUN_FREE;
                        end
                        NSTEP: begin
                            state_d = STEP;
                            sc_d    = step_count;
                        end
                        default: begin
                            state_d = STEP;
                            sc_d    = CNT_W'(1);
                        end
                    endcase
                end
            end
            STEP: begin
                if (ip_oob) begin
                    state_d = HALT;
                end else if (sc_q == '0) begin
                    state_d = IDLE;
                end else begin
                    sc_d = sc_q - CNT_W'(1);
                end
            end
            RUN_FREE: begin
                if (ip_oob) begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LOAD;
            addr_q  <= '0;
            rc_q    <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rc_q    <= rc_d;
            sc_q    <= sc_d;
        end
    end

    // An out-of-range IP gates the clock enable and the acknowledge in the
    // very cycle it is seen, ahead of the registered move to HALT.
    assign in_ready  = (state_q == LOAD) && !final_word;
    assign rom_we    = (state_q == LOAD) && word_valid;
    assign rom_waddr = addr_q;
    assign rom_wdata = word;
    assign cpu_rstn  = (state_q == IDLE) || (state_q == STEP) ||
                       (state_q == RUN_FREE) || (state_q == HALT);
    assign cpu_ce    = !ip_oob && ((state_q == RUN_FREE) ||
                                   ((state_q == STEP) && (sc_q != '0)));
    assign step_ack  = !ip_oob && (state_q == STEP) && (sc_q == '0);
    assign halted    = (state_q == HALT);
    assign fault     = (state_q == HALT);

endmodule

// File: tb/tb_cpu_step_controller.sv
// Testbench for cpu_step_controller. Two instances share every input and
// differ only in BYTE_SWAP, so each image load checks both byte orders.
module tb_cpu_step_controller;

    localparam int WORD_W       = 32;
    localparam int ADDR_W       = 8;
    localparam int IP_W         = 16;
    localparam int RESET_CYCLES = 2;
    localparam int CNT_W        = 16;
    localparam int NB           = WORD_W / 8;
    localparam int DEPTH        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_last = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              step_req = 1'b0;
    logic [CNT_W-1:0]  step_count = '0;
    logic [IP_W-1:0]   ip = '0;

    logic              in_ready, rom_we, step_ack, cpu_rstn, cpu_ce, halted, fault;
    logic [ADDR_W-1:0] rom_waddr;
    logic [WORD_W-1:0] rom_wdata;

    logic              in_ready_b, rom_we_b, step_ack_b, cpu_rstn_b, cpu_ce_b, halted_b, fault_b;
    logic [ADDR_W-1:0] rom_waddr_b;
    logic [WORD_W-1:0] rom_wdata_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_step_controller #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .IP_W(IP_W), .BYTE_SWAP(1'b1),
        .RESET_CYCLES(RESET_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .rom_we(rom_we),
        .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .mode(mode),
        .step_req(step_req), .step_count(step_count), .step_ack(step_ack),
        .ip(ip), .cpu_rstn(cpu_rstn), .cpu_ce(cpu_ce), .halted(halted),
        .fault(fault)
    );

    cpu_step_controller #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .IP_W(IP_W), .BYTE_SWAP(1'b0),
        .RESET_CYCLES(RESET_CYCLES), .CNT_W(CNT_W)
    ) dut_le (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_b), .rom_we(rom_we_b),
        .rom_waddr(rom_waddr_b), .rom_wdata(rom_wdata_b), .mode(mode),
        .step_req(step_req), .step_count(step_count), .step_ack(step_ack_b),
        .ip(ip), .cpu_rstn(cpu_rstn_b), .cpu_ce(cpu_ce_b), .halted(halted_b),
        .fault(fault_b)
    );

    // Write and reset-release log, sampled mid-cycle.
    int          cyc = 0;
    int          wr_addr[$];
    int          wr_cyc[$];
    int          rise_cyc[$];
    logic [31:0] wr_data[$];
    logic [31:0] wr_data_le[$];
    logic        cpu_rstn_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rom_we) begin
            wr_addr.push_back(int'(rom_waddr));
            wr_data.push_back(rom_wdata);
            wr_cyc.push_back(cyc);
        end
        if (rom_we_b) wr_data_le.push_back(rom_wdata_b);
        if (cpu_rstn && !cpu_rstn_prev) rise_cyc.push_back(cyc);
        cpu_rstn_prev = cpu_rstn;
    end

    logic [7:0] img[$];

    // Reference packing: word w is bytes w*NB .. w*NB+NB-1 of the image,
    // missing bytes read as zero, first byte at MSB when swap is set.
    function automatic logic [31:0] modelWord(input int w, input bit swap);
        logic [31:0] r = '0;
        for (int b = 0; b < NB; b++) begin
            int k = w * NB + b;
            logic [7:0] v = (k < img.size()) ? img[k] : 8'h00;
            if (swap) r = (r << 8) | {24'h0, v};
            else      r = r | ({24'h0, v} << (8 * b));
        end
        return r;
    endfunction

    // Steps granted for one request: N-step uses the count, single-step one.
    function automatic int modelSteps(input logic [1:0] m, input int cnt);
        return (m == 2'b10) ? cnt : 1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; step_req = 1'b0; mode = 2'b00; ip = '0;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_rom_we", rom_we, 0);
        checkOutput("rst_rom_waddr", rom_waddr, 0);
        checkOutput("rst_rom_wdata", rom_wdata, 0);
        checkOutput("rst_rom_wdata_le", rom_wdata_b, 0);
        checkOutput("rst_cpu_rstn", cpu_rstn, 0);
        checkOutput("rst_cpu_ce", cpu_ce, 0);
        checkOutput("rst_step_ack", step_ack, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_fault", fault, 0);
        nextCycle();
        rstn = 1'b1;
    endtask

    // Offers the image byte by byte; gives up on a byte after 20 stalled cycles.
    task automatic sendBytes(input bit use_last, output int accepted);
        bit got;
        accepted = 0;
        for (int i = 0; i < img.size(); i++) begin
            in_valid = 1'b1;
            in_data  = img[i];
            in_last  = use_last && (i == img.size() - 1);
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
                nextCycle();
            end
            if (!got) break;
            accepted++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic loadAndCheck(input bit use_last);
        int base    = wr_addr.size();
        int base_le = wr_data_le.size();
        int rbase   = rise_cyc.size();
        int n       = img.size();
        int nwords  = (n + NB - 1) / NB;
        int exp_acc;
        int acc;
        if (nwords > DEPTH) nwords = DEPTH;
        exp_acc = use_last ? n : ((n < DEPTH * NB) ? n : DEPTH * NB);
        sendBytes(use_last, acc);
        checkOutput("bytes_accepted", acc, exp_acc);
        for (int w = 0; w < 40 && rise_cyc.size() == rbase; w++) nextCycle();
        checkOutput("wr_count", wr_addr.size() - base, nwords);
        checkOutput("wr_count_le", wr_data_le.size() - base_le, nwords);
        for (int i = 0; i < nwords && base + i < wr_addr.size(); i++) begin
            checkOutput("wr_addr", wr_addr[base + i], i);
            checkOutput("wr_data_be", wr_data[base + i], modelWord(i, 1'b1));
        end
        for (int i = 0; i < nwords && base_le + i < wr_data_le.size(); i++)
            checkOutput("wr_data_le", wr_data_le[base_le + i], modelWord(i, 1'b0));
        checkOutput("rstn_rise_seen", rise_cyc.size() - rbase, 1);
        if (rise_cyc.size() > rbase && wr_cyc.size() > base)
            checkOutput("rstn_rise_delay", rise_cyc[rbase] - wr_cyc[wr_cyc.size() - 1], RESET_CYCLES + 1);
        @(negedge clk);
        checkOutput("in_ready_after_load", in_ready, 0);
        checkOutput("waddr_hold", rom_waddr, nwords - 1);
        checkOutput("idle_ce", cpu_ce, 0);
        nextCycle();
    endtask

    // One step request from IDLE. With spam set, step_req stays high and mode
    // is forced to free-run while the request is in flight; both must be ignored.
    task automatic applyStimulus(input logic [1:0] m, input int cnt, input int exp_ce,
                                 input int exp_delay, input bit spam);
        int ce_n = 0;
        int ack_at = -1;
        int pat_err = 0;
        mode = m;
        step_count = CNT_W'(cnt);
        step_req = 1'b1;
        ip = IP_W'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        checkOutput("req_cycle_ce", cpu_ce, 0);
        nextCycle();
        step_req = spam;
        if (spam) mode = 2'b00;
        for (int d = 1; d <= 40 && ack_at < 0; d++) begin
            @(negedge clk);
            if (cpu_ce) begin
                ce_n++;
                if (d > exp_ce) pat_err++;
            end else if (d <= exp_ce) begin
                pat_err++;
            end
            if (step_ack) ack_at = d;
            nextCycle();
            ip = IP_W'($urandom_range(0, DEPTH - 1));
        end
        step_req = 1'b0;
        mode = m;
        checkOutput("ce_cycles", ce_n, exp_ce);
        checkOutput("ack_delay", ack_at, exp_delay);
        checkOutput("ce_pattern_errors", pat_err, 0);
        @(negedge clk);
        checkOutput("post_ack_ack", step_ack, 0);
        checkOutput("post_ack_ce", cpu_ce, 0);
        nextCycle();
    endtask

    typedef struct {
        logic [1:0] mode;
        int         count;
        int         exp_ce;
        int         exp_delay;
        bit         spam;
    } step_vec_t;

    step_vec_t vecs[6];

    initial begin
        int ce_n;
        int ack_n;

        vecs[0] = '{2'b10, 3, 3, 4, 1'b0};
        vecs[1] = '{2'b10, 0, 0, 1, 1'b0};
        vecs[2] = '{2'b01, 9, 1, 2, 1'b0};
        vecs[3] = '{2'b11, 5, 1, 2, 1'b0};
        vecs[4] = '{2'b10, 1, 1, 2, 1'b1};
        vecs[5] = '{2'b10, 6, 6, 7, 1'b1};

        $display("[TB] start");
        #2;
        doReset();

        // 8-byte image, big-endian instance gives 01020304 / 05060708.
        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        loadAndCheck(1'b1);

        foreach (vecs[i])
            applyStimulus(vecs[i].mode, vecs[i].count, vecs[i].exp_ce,
                          vecs[i].exp_delay, vecs[i].spam);

        for (int r = 0; r < 16; r++) begin
            logic [1:0] m = 2'($urandom_range(1, 3));
            int cnt = $urandom_range(0, 9);
            int n = modelSteps(m, cnt);
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkOutput("gap_ce", cpu_ce, 0);
                nextCycle();
            end
            applyStimulus(m, cnt, n, n + 1, 1'($urandom_range(0, 1)));
        end

        // Free run, a stray single-step request midway, then IP leaves the ROM.
        mode = 2'b00; step_req = 1'b1; ip = 16'd10;
        nextCycle();
        step_req = 1'b0;
        ce_n = 0;
        for (int d = 0; d < 6; d++) begin
            if (d == 3) begin mode = 2'b01; step_req = 1'b1; end
            @(negedge clk);
            if (cpu_ce) ce_n++;
            nextCycle();
            step_req = 1'b0;
        end
        checkOutput("free_run_ce_cycles", ce_n, 6);
        ip = 16'd256;
        @(negedge clk);
        checkOutput("oob_ce_gate", cpu_ce, 0);
        checkOutput("oob_not_yet_halted", halted, 0);
        nextCycle();
        ip = 16'd5;
        @(negedge clk);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_fault", fault, 1);
        checkOutput("halt_ce", cpu_ce, 0);
        nextCycle();
        mode = 2'b01;
        ce_n = 0; ack_n = 0;
        for (int d = 0; d < 8; d++) begin
            step_req = 1'b1;
            @(negedge clk);
            if (cpu_ce) ce_n++;
            if (step_ack) ack_n++;
            nextCycle();
        end
        step_req = 1'b0;
        checkOutput("halt_ignores_ce", ce_n, 0);
        checkOutput("halt_ignores_ack", ack_n, 0);
        checkOutput("halt_sticky", halted, 1);

        // Little-endian instance gives DDCCBBAA / 000000EE; then abort an N-step.
        doReset();
        img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        loadAndCheck(1'b1);
        mode = 2'b10; step_count = 16'd5; step_req = 1'b1; ip = 16'd20;
        nextCycle();
        step_req = 1'b0;
        ce_n = 0;
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            if (cpu_ce) ce_n++;
            nextCycle();
        end
        checkOutput("nstep_before_oob_ce", ce_n, 2);
        ip = 16'hFFFF;
        @(negedge clk);
        checkOutput("nstep_oob_ce_gate", cpu_ce, 0);
        nextCycle();
        ip = 16'd3;
        ce_n = 0; ack_n = 0;
        for (int d = 0; d < 10; d++) begin
            @(negedge clk);
            if (cpu_ce) ce_n++;
            if (step_ack) ack_n++;
            nextCycle();
        end
        checkOutput("aborted_no_ack", ack_n, 0);
        checkOutput("aborted_no_ce", ce_n, 0);
        checkOutput("aborted_fault", fault, 1);

        // Reset in the middle of a word; the next load must start clean at 0.
        doReset();
        img = {8'h11, 8'h22};
        sendBytes(1'b0, ce_n);
        checkOutput("partial_accepted", ce_n, 2);
        doReset();
        img.delete();
        for (int i = 0; i < 300 * NB; i++) img.push_back(8'($urandom_range(0, 255)));
        loadAndCheck(1'b0);

        // Reset in the middle of an N-step, then reload.
        mode = 2'b10; step_count = 16'd10; step_req = 1'b1; ip = 16'd0;
        nextCycle();
        step_req = 1'b0;
        nextCycle();
        nextCycle();
        doReset();
        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        loadAndCheck(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
